// File: rtl/attn_seq_ctrl.sv
// attn_seq_ctrl: instruction sequencer for the attention fullchip.
//
// The block takes a run command plus a stream of Q and K vectors. It then issues the chip's
// load, execute, accumulate and normalized-read instruction phases, one word per cycle. It
// returns each output row tagged with its Q index.
//
// Optional feature: define ATTN_SEQ_RAW_READ_EN to add the raw_mode input. It is latched with
// start. When it is 1, read words select the raw core output (out_sel) and the result delay
// drops to one cycle.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   start, cmd_nq       run request and Q vector count (1..MAX_Q), sampled only when idle
//   raw_mode            (ATTN_SEQ_RAW_READ_EN only) select raw core output for this run
//   in_valid/in_ready   Q then K vector beats on in_data
//   inst, mem_in        registered instruction word and data word to the chip
//   chip_out            chip output bus
//   res_valid/data/idx  captured chip output row and its Q index
//   busy, done          run in progress, one-cycle end-of-run pulse
module attn_seq_ctrl #(
  parameter int unsigned col       = 8,
  parameter int unsigned bw        = 8,
  parameter int unsigned bw_psum   = 20,
  parameter int unsigned pr        = 16,
  parameter int unsigned MAX_Q     = 16,
  parameter int unsigned ARRAY_LAT = 16,
  parameter int unsigned SFP_LAT   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [6:0]               cmd_nq,
`ifdef ATTN_SEQ_RAW_READ_EN
  input  logic                     raw_mode,
`endif
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [pr*bw-1:0]         in_data,
  output logic [19:0]              inst,
  output logic [pr*bw-1:0]         mem_in,
  input  logic [bw_psum*col-1:0]   chip_out,
  output logic                     res_valid,
  output logic [bw_psum*col-1:0]   res_data,
  output logic [6:0]               res_idx,
  output logic                     busy,
  output logic                     done
);

  // Instruction control bits [8:0]
  localparam logic [8:0] PmemWr  = 9'h001;
  localparam logic [8:0] PmemRd  = 9'h002;
  localparam logic [8:0] OfifoRd = 9'h004;
  localparam logic [8:0] Execute = 9'h008;
  localparam logic [8:0] Load    = 9'h010;
  localparam logic [8:0] QmemRd  = 9'h020;
  localparam logic [8:0] QmemWr  = 9'h040;
  localparam logic [8:0] KmemRd  = 9'h080;
  localparam logic [8:0] KmemWr  = 9'h100;

  localparam logic [7:0] ColLast   = 8'(col - 1);
  localparam logic [7:0] WaitLast  = 8'(ARRAY_LAT - 1);
  localparam logic [7:0] DrainLast = 8'(SFP_LAT - 1);
  localparam logic [7:0] MaxQ      = 8'(MAX_Q);

  typedef enum logic [3:0] {
    StIdle, StWrQ, StWrK, StLoad, StExec, StWait, StAcc, StRd, StDrain, StDone
  } state_e;

  state_e                   state_q;
  logic [7:0]               cnt_q;
  logic [7:0]               nq_q;
  logic [19:0]              inst_q;
  logic [pr*bw-1:0]         mem_q;
  logic                     busy_q;
  logic                     done_q;

  logic [7:0]               nq_last;
  logic [7:0]               phase_last;
  logic                     cnt_wrap;
  logic                     start_ok;
  logic                     raw_sel;

  function automatic logic [19:0] mk_inst(input logic [8:0] ctl, input logic [6:0] addr,
                                          input logic out_sel);
    return {out_sel, addr, 3'b000, ctl};
  endfunction

  assign nq_last  = nq_q - 8'd1;
  assign start_ok = (state_q == StIdle) && start && (cmd_nq != 7'd0) && ({1'b0, cmd_nq} <= MaxQ);
  assign in_ready = (state_q == StWrQ) || (state_q == StWrK);

  // Length of the current phase minus one; the counter wraps to zero on it.
  always_comb begin
    phase_last = '0;
    unique case (state_q)
      StWrQ, StExec, StAcc, StRd: phase_last = nq_last;
      StWrK, StLoad:              phase_last = ColLast;
      StWait:                     phase_last = WaitLast;
      StDrain:                    phase_last = DrainLast;
      default:                    phase_last = '0;
    endcase
  end

  assign cnt_wrap = (cnt_q == phase_last);

`ifdef ATTN_SEQ_RAW_READ_EN
  logic raw_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      raw_q <= 1'b0;
    end else if (start_ok) begin
      raw_q <= raw_mode;
    end
  end

  assign raw_sel = raw_q;
`else
  assign raw_sel = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      nq_q    <= '0;
      inst_q  <= '0;
      mem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      inst_q <= '0;
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_ok) begin
            nq_q    <= {1'b0, cmd_nq};
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StWrQ;
          end
        end
        StWrQ, StWrK: begin
          // Bubbles leave inst at zero and the address counter untouched.
          if (in_valid) begin
            inst_q <= mk_inst((state_q == StWrQ) ? QmemWr : KmemWr, cnt_q[6:0], 1'b0);
            mem_q  <= in_data;
            if (cnt_wrap) begin
              cnt_q   <= '0;
              state_q <= (state_q == StWrQ) ? StWrK : StLoad;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
        end
        StLoad, StExec, StWait, StAcc, StRd, StDrain: begin
          unique case (state_q)
            StLoad:  inst_q <= mk_inst(KmemRd | Load, cnt_q[6:0], 1'b0);
            StExec:  inst_q <= mk_inst(QmemRd | Execute, cnt_q[6:0], 1'b0);
            StAcc:   inst_q <= mk_inst(OfifoRd | PmemWr, cnt_q[6:0], 1'b0);
            StRd:    inst_q <= mk_inst(PmemRd, cnt_q[6:0], raw_sel);
            default: inst_q <= '0;
          endcase
          if (cnt_wrap) begin
            cnt_q <= '0;
            unique case (state_q)
              StLoad:  state_q <= StExec;
              StExec:  state_q <= StWait;
              StWait:  state_q <= StAcc;
              StAcc:   state_q <= StRd;
              StRd:    state_q <= StDrain;
              default: state_q <= StDone;
            endcase
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StDone: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Result delay line: stage 0 loads in step with the pmem_rd word on inst, so tapping stage
  // SFP_LAT-1 lands res_valid SFP_LAT cycles after that word (stage 0 for raw reads).
  logic [SFP_LAT-1:0]       dl_vld_q;
  logic [6:0]               dl_idx_q [SFP_LAT];
  logic                     res_valid_q;
  logic [bw_psum*col-1:0]   res_data_q;
  logic [6:0]               res_idx_q;
  logic                     tap_vld;
  logic [6:0]               tap_idx;

  assign tap_vld = raw_sel ? dl_vld_q[0] : dl_vld_q[SFP_LAT-1];
  assign tap_idx = raw_sel ? dl_idx_q[0] : dl_idx_q[SFP_LAT-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dl_vld_q    <= '0;
      for (int i = 0; i < SFP_LAT; i++) begin
        dl_idx_q[i] <= '0;
      end
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_idx_q   <= '0;
    end else begin
      dl_vld_q[0] <= (state_q == StRd);
      dl_idx_q[0] <= cnt_q[6:0];
      for (int i = 1; i < SFP_LAT; i++) begin
        dl_vld_q[i] <= dl_vld_q[i-1];
        dl_idx_q[i] <= dl_idx_q[i-1];
      end
      res_valid_q <= tap_vld;
      if (tap_vld) begin
        res_data_q <= chip_out;
        res_idx_q  <= tap_idx;
      end
    end
  end

  assign inst      = inst_q;
  assign mem_in    = mem_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_idx   = res_idx_q;

endmodule
